vregfile_param: RTL
===================

# vregfile_param

Parametrised vector register file for the vector datapath: NREGS registers of LANES x WIDTH bits, two combinational vector read ports and one registered write port with per-lane write mask. Adds a per-register pending scoreboard for hazard detection and a sequential clear engine that zeroes the file one register per cycle. Sits between decode/issue (reads, reservations) and writeback (writes) in the vector pipeline.

## Interface
- LANES, default 4, number of elements per vector register
- WIDTH, default 32, bits per element
- NREGS, default 16, number of vector registers (≥2); AW = $clog2(NREGS)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  AW  write register index
- wr_mask  in  LANES  per-lane write enable; bit i gates lane i
- wr_data  in  LANES x WIDTH  write vector, unpacked [LANES-1:0]
- rd_addr1, rd_addr2  in  AW  read indices
- r1v, r2v  out  LANES x WIDTH  read vectors, unpacked [0:LANES-1]
- r1_pend, r2_pend  out  1  pending bit of rd_addr1 / rd_addr2
- rsv_valid  in  1  reserve (mark pending) register rsv_addr
- rsv_addr  in  AW  register to reserve
- clr_req  in  1  start a full-file clear sweep
- clr_busy  out  1  clear sweep in progress

## Operation
- Reset (rst_n low, async): all register lanes 0, all pending bits 0, FSM IDLE, sweep counter 0. Outputs: r1v/r2v = 0, r1/r2_pend = 0, wr_ready = 1, clr_busy = 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req sampled high; counter loads 0.
  - CLEAR: each cycle zeroes all lanes of register[counter] and its pending bit; counter increments; after register NREGS-1 is cleared -> IDLE.
  - clr_req while in CLEAR ignored.
- wr_ready = (state == IDLE). Accepted write updates only lanes with wr_mask[i]=1; unmasked lanes hold. Accepted write clears pending bit of wr_addr.
- rsv_valid honoured only in IDLE; sets pending bit of rsv_addr.
- Same-cycle accepted write and reserve to the same address: reserve wins, pending bit ends 1.
- Out-of-range addresses (≥ NREGS when NREGS not a power of two): writes and reservations dropped; reads return 0 and pend 0.
- Reads are combinational from stored state at all times, including during CLEAR (already-swept registers read 0).

## Timing
- Write latency: data visible on r1v/r2v the cycle after acceptance (1 cycle), unless bypass compiled in.
- Pending set/clear visible on r*_pend the cycle after the causing edge.
- clr_req at edge N: clr_busy high from N+1 through N+NREGS; register k reads 0 from edge N+1+k; clr_busy low and wr_ready high after edge N+NREGS.
- Write presented with wr_ready low is not taken; producer holds wr_valid/wr_addr/wr_mask/wr_data until accepted.
- rst_n asserted mid-sweep: immediate return to IDLE, file zeroed, counter 0; no sweep resumes after release.
- Reset release synchronised externally; block takes no action on deassertion edge.

## Configuration
- VREGFILE_BYPASS_EN defined: read port whose address equals an accepted same-cycle wr_addr returns the merged vector combinationally (wr_data on masked lanes, stored data elsewhere); r*_pend for that port reads 0 unless rsv_valid targets the same address that cycle. Zero-latency write-to-read.
- Undefined: no forwarding; reads always reflect stored state; 1-cycle write-to-read latency as above.

## Test plan
- Reset: assert rst_n=0 mid-operation -> r1v/r2v all 0, r1_pend=0, wr_ready=1, clr_busy=0 immediately, no clock required.
- Masked write: write reg 3 = {0x11,0x22,0x33,0x44} mask 4'b1111, then reg 3 = {0xAA,0xBB,0xCC,0xDD} mask 4'b0101 -> r1v(addr 3) = {0xAA,0x22,0xCC,0x44} (lane 0 first) next cycle.
- Scoreboard: rsv reg 5 -> r1_pend=1 next cycle; write reg 5 -> r1_pend=0 next cycle; simultaneous rsv+write reg 5 -> r1_pend stays 1 and data updated.
- Clear sweep: fill all 16 regs with 0xFFFFFFFF, pulse clr_req -> clr_busy high exactly 16 cycles, wr_ready low throughout, write during sweep not accepted, all regs 0 and pend 0 afterwards.
- Reset mid-sweep at cycle 7 of CLEAR -> clr_busy 0 immediately, all regs 0, wr_ready 1.
- Bypass (with VREGFILE_BYPASS_EN): write reg 2 mask 4'b0010 lane1=0x5 while rd_addr1=2 -> r1v lane1=0x5 same cycle, others old; without macro old value until next cycle.

Source files
------------

// File: rtl/vregfile_param.sv
// vregfile_param: vector register file, NREGS x LANES x WIDTH bits.
// Two combinational read ports, one write port with per-lane mask,
// a per-register pending scoreboard, and a one-register-per-cycle clear sweep.
// Optional macro VREGFILE_BYPASS_EN: forward an accepted write to a read port
// whose address matches in the same cycle.
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready.
// wr_ready is high only while the sweep is idle. The producer holds
// wr_valid/wr_addr/wr_mask/wr_data stable until that transfer happens.
module vregfile_param #(
  parameter int LANES = 4,
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_mask,
  input  logic [WIDTH-1:0] wr_data [LANES-1:0],
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] r1v [0:LANES-1],
  output logic [WIDTH-1:0] r2v [0:LANES-1],
  output logic             r1_pend,
  output logic             r2_pend,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             dbg_state
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt;
  logic [WIDTH-1:0]  mem [NREGS][LANES];
  logic [NREGS-1:0]  pend;

  logic wr_fire, rsv_fire, rd1_ok, rd2_ok;

  // Addresses at or above NREGS exist only when NREGS is not a power of two.
  assign wr_ready  = (state_q == S_IDLE);
  assign clr_busy  = (state_q == S_CLEAR);
  assign dbg_state = (state_q == S_CLEAR);
  assign wr_fire   = wr_valid && wr_ready && (int'(wr_addr) < NREGS);
  assign rsv_fire  = rsv_valid && (state_q == S_IDLE) && (int'(rsv_addr) < NREGS);
  assign rd1_ok    = (int'(rd_addr1) < NREGS);
  assign rd2_ok    = (int'(rd_addr2) < NREGS);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: start a sweep on clr_req, leave after the last register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_req) state_d = S_CLEAR;
      S_CLEAR: if (cnt == LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sweep counter: held at 0 while idle so a new sweep always starts at reg 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (state_q == S_CLEAR) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    else                         cnt <= '0;
  end

  // Register storage: sweep zeroes one register, otherwise masked write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        for (int l = 0; l < LANES; l++)
          mem[r][l] <= '0;
    end else if (state_q == S_CLEAR) begin
      for (int l = 0; l < LANES; l++)
        mem[cnt][l] <= '0;
    end else if (wr_fire) begin
      for (int l = 0; l < LANES; l++)
        if (wr_mask[l]) mem[wr_addr][l] <= wr_data[l];
    end
  end

  // Pending scoreboard: write clears, reserve sets; reserve is applied last so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (state_q == S_CLEAR) begin
      pend[cnt] <= 1'b0;
    end else begin
      if (wr_fire)  pend[wr_addr]  <= 1'b0;
      if (rsv_fire) pend[rsv_addr] <= 1'b1;
    end
  end

`ifdef VREGFILE_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = wr_fire && (wr_addr == rd_addr1);
  assign byp2 = wr_fire && (wr_addr == rd_addr2);
`endif

  // Read ports: stored state, zero for out-of-range, optional write forwarding.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      r1v[l] = '0;
      r2v[l] = '0;
      if (rd1_ok) r1v[l] = mem[rd_addr1][l];
      if (rd2_ok) r2v[l] = mem[rd_addr2][l];
`ifdef VREGFILE_BYPASS_EN
      if (byp1 && wr_mask[l]) r1v[l] = wr_data[l];
      if (byp2 && wr_mask[l]) r2v[l] = wr_data[l];
`endif
    end
    r1_pend = rd1_ok && pend[rd_addr1];
    r2_pend = rd2_ok && pend[rd_addr2];
`ifdef VREGFILE_BYPASS_EN
    if (byp1) r1_pend = rsv_fire && (rsv_addr == rd_addr1);
    if (byp2) r2_pend = rsv_fire && (rsv_addr == rd_addr2);
`endif
  end

endmodule
